// File: rtl/alu_issue_sched_if.sv
// Scheduler-facing bundle: RS request/grant, ALU issue/done, CDB offer/accept, RS free.
interface alu_issue_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*TAG_W-1:0] tag;
  logic [NUM_REQ-1:0]       grant;
  logic                     issue;
  logic [IDX_W-1:0]         issue_idx;
  logic                     alu_done;
  logic [31:0]              alu_res;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [31:0]              cdb_value;
  logic                     cdb_ready;
  logic [NUM_REQ-1:0]       free;
  logic                     busy;

  // scheduler side
  modport slave (
    input  req, tag, alu_done, alu_res, cdb_ready,
    output grant, issue, issue_idx, cdb_valid, cdb_tag, cdb_value, free, busy
  );

  // environment side (RS / ALU / CDB)
  modport master (
    output req, tag, alu_done, alu_res, cdb_ready,
    input  grant, issue, issue_idx, cdb_valid, cdb_tag, cdb_value, free, busy
  );
endinterface

// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler for one shared multi-cycle ALU.
// Picks one ready RS entry, issues it, holds the result until the CDB
// accepts it, then frees the entry. All outputs registered.
// Optional macro ALU_SCHED_B2B_EN: re-issue in the CDB transfer cycle,
// removing the IDLE bubble between transactions.
module alu_issue_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  alu_issue_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, BCAST} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [TAG_W-1:0]   htag, htag_n;
  logic [TAG_W-1:0]   ctag_q, ctag_n;
  logic [31:0]        cval_q, cval_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [NUM_REQ-1:0] free_q, free_n;
  logic               issue_q, issue_n;
  logic               valid_q, valid_n;
  logic               busy_q;
  logic [IDX_W:0]     pick_idle;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // {found, index}: first set bit scanning base, base+1, ... modulo NUM_REQ
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   base);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(base) + k) % NUM_REQ;
      if (!found && r[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  assign pick_idle = rr_pick(bus.req, ptr);

`ifdef ALU_SCHED_B2B_EN
  // entry being freed is masked; scan starts at the post-transfer pointer
  logic [IDX_W:0] pick_b2b;
  assign pick_b2b = rr_pick(bus.req & ~(NUM_REQ'(1) << idx_q), wrap_inc(idx_q));
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst || flush) state <= IDLE;
    else              state <= state_n;
  end

  // next state and next registered-output values
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx_q;
    htag_n  = htag;
    ctag_n  = ctag_q;
    cval_n  = cval_q;
    valid_n = valid_q;
    grant_n = '0;
    issue_n = 1'b0;
    free_n  = '0;
    case (state)
      IDLE: begin
        if (pick_idle[IDX_W]) begin
          idx_n   = pick_idle[IDX_W-1:0];
          grant_n = NUM_REQ'(1) << pick_idle[IDX_W-1:0];
          issue_n = 1'b1;
          htag_n  = bus.tag[int'(pick_idle[IDX_W-1:0])*TAG_W +: TAG_W];
          state_n = EXEC;
        end
      end
      EXEC: begin
        // done may coincide with the issue pulse (zero-latency ALU)
        if (bus.alu_done) begin
          valid_n = 1'b1;
          ctag_n  = htag;
          cval_n  = bus.alu_res;
          state_n = BCAST;
        end
      end
      BCAST: begin
        // offer held stable until the CDB accepts; alu_done is ignored here
        if (bus.cdb_ready) begin
          valid_n = 1'b0;
          free_n  = NUM_REQ'(1) << idx_q;
          ptr_n   = wrap_inc(idx_q);
          state_n = IDLE;
`ifdef ALU_SCHED_B2B_EN
          if (pick_b2b[IDX_W]) begin
            idx_n   = pick_b2b[IDX_W-1:0];
            grant_n = NUM_REQ'(1) << pick_b2b[IDX_W-1:0];
            issue_n = 1'b1;
            htag_n  = bus.tag[int'(pick_b2b[IDX_W-1:0])*TAG_W +: TAG_W];
            state_n = EXEC;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // output / datapath registers; flush clears everything except ptr
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if (rst) ptr <= '0;
      idx_q   <= '0;
      htag    <= '0;
      ctag_q  <= '0;
      cval_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      issue_q <= 1'b0;
      free_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr     <= ptr_n;
      idx_q   <= idx_n;
      htag    <= htag_n;
      ctag_q  <= ctag_n;
      cval_q  <= cval_n;
      valid_q <= valid_n;
      grant_q <= grant_n;
      issue_q <= issue_n;
      free_q  <= free_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  assign bus.grant     = grant_q;
  assign bus.issue     = issue_q;
  assign bus.issue_idx = idx_q;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_tag   = ctag_q;
  assign bus.cdb_value = cval_q;
  assign bus.free      = free_q;
  assign bus.busy      = busy_q;

  // protocol checks
  a_done_in_bcast: assert property (@(posedge clk) disable iff (rst || flush)
    !(state == BCAST && bus.alu_done));
  a_grant_oh: assert property (@(posedge clk) $onehot0(grant_q));
  a_free_oh:  assert property (@(posedge clk) $onehot0(free_q));

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed + randomized bench for alu_issue_sched against a transaction-level model.
module tb_alu_issue_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  alu_issue_sched_if #(.NUM_REQ(N), .TAG_W(3)) bus ();

  alu_issue_sched #(.NUM_REQ(N), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
  );

  int         total = 0;
  int         bad   = 0;
  logic [3:0] req_v;
  logic [2:0] tags_v [N];
  int         ptr_m;
  int         pend;

  // model: first requester at or after base, wrapping
  function automatic int pick(input logic [3:0] r, input int base);
    logic [7:0] d, low;
    d   = {r, r} >> base;
    low = d & (~d + 8'd1);
    return ($clog2(low) + base) % N;
  endfunction

  task automatic check(input string nm, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req = req_v;
    for (int i = 0; i < N; i++) bus.tag[i*3 +: 3] = tags_v[i];
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_grant"}, 32'(bus.grant), 0);
    check({nm, "_issue"}, 32'(bus.issue), 0);
    check({nm, "_idx"},   32'(bus.issue_idx), 0);
    check({nm, "_valid"}, 32'(bus.cdb_valid), 0);
    check({nm, "_tag"},   32'(bus.cdb_tag), 0);
    check({nm, "_value"}, bus.cdb_value, 0);
    check({nm, "_free"},  32'(bus.free), 0);
    check({nm, "_busy"},  32'(bus.busy), 0);
  endtask

  task automatic check_grant(input int g);
    check("grant", 32'(bus.grant), 32'(1) << g);
    check("issue", 32'(bus.issue), 1);
    check("issue_idx", 32'(bus.issue_idx), 32'(g));
    check("busy", 32'(bus.busy), 1);
  endtask

  // one full transaction: grant (unless already granted), done after dly,
  // stalls cycles of CDB backpressure, then transfer and free
  task automatic txn(input int dly, input int stalls, input logic [31:0] val,
                     input logic [3:0] add);
    int g, e;
    if (pend < 0) begin
      drive();
      tick();
      g = pick(req_v, ptr_m);
      check_grant(g);
      pend = g;
    end
    g = pend;
    req_v[g] = 1'b0;
    req_v = req_v | (add & ~(4'b1 << g));
    drive();
    repeat (dly) begin
      tick();
      check("exec_valid", 32'(bus.cdb_valid), 0);
      check("exec_grant", 32'(bus.grant), 0);
    end
    bus.alu_done = 1'b1;
    bus.alu_res  = val;
    tick();
    bus.alu_done = 1'b0;
    check("cdb_valid", 32'(bus.cdb_valid), 1);
    check("cdb_tag", 32'(bus.cdb_tag), 32'(tags_v[g]));
    check("cdb_value", bus.cdb_value, val);
    check("free_early", 32'(bus.free), 0);
    repeat (stalls) begin
      bus.cdb_ready = 1'b0;
      tick();
      check("stall_valid", 32'(bus.cdb_valid), 1);
      check("stall_tag", 32'(bus.cdb_tag), 32'(tags_v[g]));
      check("stall_value", bus.cdb_value, val);
      check("stall_free", 32'(bus.free), 0);
      check("stall_grant", 32'(bus.grant), 0);
    end
    bus.cdb_ready = 1'b1;
    tick();
    check("xfer_valid", 32'(bus.cdb_valid), 0);
    check("free", 32'(bus.free), 32'(1) << g);
    ptr_m = (g + 1) % N;
`ifdef ALU_SCHED_B2B_EN
    if (req_v != 4'b0) begin
      e = pick(req_v, ptr_m);
      check_grant(e);
      pend = e;
    end else begin
      check("b2b_nogrant", 32'(bus.grant), 0);
      pend = -1;
    end
`else
    e = 0;
    check("bubble_grant", 32'(bus.grant), e);
    check("bubble_busy", 32'(bus.busy), 0);
    pend = -1;
`endif
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_v = '0;
    for (int i = 0; i < N; i++) tags_v[i] = 3'(i + 1);
    drive();
    bus.alu_done  = 1'b0;
    bus.alu_res   = '0;
    bus.cdb_ready = 1'b1;
    ptr_m = 0;
    pend  = -1;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;

    // round robin: all four request, each drops after its grant
    req_v = 4'b1111;
    for (int t = 0; t < 4; t++) txn(1, 0, 32'h100 + 32'(t), 4'b0);
    req_v = 4'b1001;
    txn(0, 0, 32'h55, 4'b0);            // ptr back at 0: grants 0

    // basic transaction: entry 2, tag 5, done at issue+2, ready high
    if (pend < 0) req_v = 4'b0100;
    else          req_v = 4'b0;
    tags_v[2] = 3'd5;
    while (pend >= 0 || req_v != 4'b0100) begin
      txn(0, 0, 32'h1, 4'b0);
      if (pend < 0) req_v = 4'b0100;
    end
    txn(2, 0, 32'h0000_00AA, 4'b0);

    // backpressure with wrap from ptr 3
    while (pend >= 0) txn(0, 0, 32'h2, 4'b0);
    req_v = 4'b0001;
    txn(1, 3, 32'hDEAD_BEEF, 4'b0);

    // flush in EXEC coincident with alu_done; ptr must survive
    while (pend >= 0) txn(0, 0, 32'h3, 4'b0);
    req_v = 4'b0100;
    drive();
    tick();
    check_grant(pick(req_v, ptr_m));
    req_v = 4'b0;
    drive();
    bus.alu_done = 1'b1;
    bus.alu_res  = 32'h77;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.alu_done = 1'b0;
    check_zero("flush");
    tick();
    check("flush_valid2", 32'(bus.cdb_valid), 0);
    req_v = 4'b1011;
    txn(0, 1, 32'h1234, 4'b0);

    // reset while in BCAST with ptr 3
    while (pend >= 0) txn(0, 0, 32'h4, 4'b0);
    req_v = 4'b0100;
    txn(0, 0, 32'h5, 4'b0);
    while (pend >= 0 || ptr_m != 3) begin
      if (pend < 0) req_v = 4'b0100;
      txn(0, 0, 32'h6, 4'b0);
    end
    req_v = 4'b0001;
    drive();
    tick();
    check_grant(pick(req_v, ptr_m));
    req_v = 4'b0;
    drive();
    bus.alu_done = 1'b1;
    bus.alu_res  = 32'h99;
    tick();
    bus.alu_done = 1'b0;
    check("rbc_valid", 32'(bus.cdb_valid), 1);
    bus.cdb_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("rst_bcast");
    ptr_m = 0;
    pend  = -1;
    req_v = 4'b1001;
    txn(1, 0, 32'h8, 4'b0);             // ptr reset to 0: grants 0

    // entry 1 in BCAST while 0 and 2 request: next pick comes from ptr 2
    while (pend >= 0) txn(0, 0, 32'h9, 4'b0);
    req_v = 4'b0010;
    txn(1, 0, 32'hA, 4'b0101);
    txn(0, 0, 32'hB, 4'b0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (pend < 0 && $urandom_range(0, 4) == 0) begin
        req_v = 4'b0;
        drive();
        tick();
        check("idle_grant", 32'(bus.grant), 0);
        check("idle_busy", 32'(bus.busy), 0);
      end else begin
        if (pend < 0) begin
          req_v = req_v | 4'($urandom_range(1, 15));
          for (int i = 0; i < N; i++) tags_v[i] = 3'($urandom_range(0, 7));
        end
        txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
